ice40_video_downscale_fb_param: RTL and testbench

- Parametrised block-average downscaler and frame buffer between a byte-wide Bayer camera stream and the ML engine's input memory loader.
- Crops a window and averages 2^BLK_LOG2 x 2^BLK_LOG2 blocks into one 8-bit gray sample per block.
- Stores an OUT_W x OUT_H frame and streams it to the ML engine as signed 16-bit words through the existing rd_rdy/rd_req/rd_done handshake.
- Single clock domain; upstream logic has already assembled the camera stream into bytes.

---
 rtl/ice40_video_downscale_fb_param.sv | 192 +++++++++++++++++++
 tb/tb_ice40_video_downscale_fb_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ice40_video_downscale_fb_param.sv
// Crop + block-average downscaler with frame buffer and ML-loader read port.
// Define DS_PINGPONG_EN for a two-bank frame buffer; default is a single bank.
module ice40_video_downscale_fb_param #(
  parameter int H_START    = 32,
  parameter int V_START    = 32,
  parameter int BLK_LOG2   = 3,
  parameter int OUT_W      = 32,
  parameter int OUT_H      = 32,
  parameter int DOUT_SHIFT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_cam_vsync,
  input  logic        i_cam_de,
  input  logic        i_cam_vld,
  input  logic [7:0]  i_cam_data,
  output logic [9:0]  o_width,
  output logic [9:0]  o_height,
  output logic        o_drop,
  input  logic        i_rd_rdy,
  output logic        o_rd_req,
  output logic        o_rd_done,
  output logic        o_we,
  output logic [15:0] o_waddr,
  output logic [15:0] o_dout
);
  localparam int N     = OUT_W * OUT_H;
  localparam int CW    = $clog2(OUT_W);
  localparam int RW    = $clog2(OUT_H);
  localparam int NW    = $clog2(N);
  localparam int AW    = 8 + 2 * BLK_LOG2;
  localparam int X_END = H_START + (OUT_W << BLK_LOG2);
  localparam int Y_END = V_START + (OUT_H << BLK_LOG2);
  localparam logic [9:0]    H0   = 10'(H_START);
  localparam logic [9:0]    V0   = 10'(V_START);
  localparam logic [NW-1:0] LAST = NW'(N - 1);
`ifdef DS_PINGPONG_EN
  localparam int FW = NW + 1;
`else
  localparam int FW = NW;
`endif

  typedef enum logic [1:0] {IDLE, READ, DONE} rd_state_t;
  rd_state_t state;

  logic                vsync_q, de_q, capturing, frame_avail;
  logic [9:0]          px_cnt, ln_cnt;
  logic [AW-1:0]       acc, lr_q, base, sum;
  logic [CW-1:0]       col, lr_addr;
  logic [RW-1:0]       row;
  logic [BLK_LOG2-1:0] subx, suby;
  logic                in_win, lr_we, fb_we, last_blk;
  logic                frame_start, vsync_rise, line_end, rd_start, rd_to_idle;
  logic [NW-1:0]       rd_addr, a1;
  logic                iss, v1;
  logic [7:0]          fb_q;
  logic [FW-1:0]       fb_waddr, fb_raddr;
  logic [AW-1:0]       line_ram [OUT_W];
  logic [7:0]          fb_mem [2**FW];

  always_comb begin
    frame_start = vsync_q & ~i_cam_vsync;
    vsync_rise  = ~vsync_q & i_cam_vsync;
    line_end    = de_q & ~i_cam_de;
    col  = CW'((px_cnt - H0) >> BLK_LOG2);
    subx = BLK_LOG2'(px_cnt - H0);
    row  = RW'((ln_cnt - V0) >> BLK_LOG2);
    suby = BLK_LOG2'(ln_cnt - V0);
    in_win = capturing && i_cam_de && i_cam_vld &&
             (int'(px_cnt) >= H_START) && (int'(px_cnt) < X_END) &&
             (int'(ln_cnt) >= V_START) && (int'(ln_cnt) < Y_END);
    // first pixel of a block column picks up the partial sum of the lines above
    base = (subx != '0) ? acc : ((suby != '0) ? lr_q : '0);
    sum  = base + AW'(i_cam_data);
    lr_we    = in_win && (subx == '1) && (suby != '1);
    fb_we    = in_win && (subx == '1) && (suby == '1);
    last_blk = fb_we && (row == RW'(OUT_H - 1)) && (col == CW'(OUT_W - 1));
    rd_start   = (state == IDLE) && frame_avail && i_rd_rdy;
    rd_to_idle = (state != IDLE) && !i_rd_rdy;
  end

`ifdef DS_PINGPONG_EN
  logic wr_bank, rd_bank, pending, rd_free;
  assign rd_free  = ((state == IDLE) && !rd_start) || rd_to_idle;
  assign fb_waddr = {wr_bank, row, col};
  assign fb_raddr = {rd_bank, rd_addr};
`else
  assign fb_waddr = {row, col};
  assign fb_raddr = rd_addr;
`endif

  always_ff @(posedge clk) begin
    if (lr_we) line_ram[col] <= sum;
    if (fb_we) fb_mem[fb_waddr] <= 8'(sum >> (2 * BLK_LOG2));
    lr_q <= line_ram[lr_addr];
    fb_q <= fb_mem[fb_raddr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_q <= 1'b0; de_q <= 1'b0; capturing <= 1'b0; frame_avail <= 1'b0;
      px_cnt <= '0; ln_cnt <= '0; acc <= '0; lr_addr <= '0;
      o_width <= '0; o_height <= '0; o_drop <= 1'b0;
      state <= IDLE; rd_addr <= '0; a1 <= '0; iss <= 1'b0; v1 <= 1'b0;
      o_rd_req <= 1'b0; o_rd_done <= 1'b0; o_we <= 1'b0; o_waddr <= '0; o_dout <= '0;
`ifdef DS_PINGPONG_EN
      wr_bank <= 1'b0; rd_bank <= 1'b0; pending <= 1'b0;
`endif
    end else begin
      vsync_q <= i_cam_vsync;
      de_q    <= i_cam_de;
      o_drop  <= 1'b0;
      if (frame_start) begin
        px_cnt <= '0; ln_cnt <= '0; lr_addr <= '0;
      end else if (line_end) begin
        ln_cnt <= ln_cnt + 1'b1; o_width <= px_cnt; px_cnt <= '0; lr_addr <= '0;
      end else if (i_cam_de && i_cam_vld) begin
        px_cnt <= px_cnt + 1'b1;
      end
      if (vsync_rise) o_height <= ln_cnt;
      if (in_win) begin
        if (subx == '0) lr_addr <= col + 1'b1;
        if (subx != '1) acc <= sum;
      end

`ifdef DS_PINGPONG_EN
      if (frame_start) capturing <= 1'b1;
      if (rd_to_idle) begin
        if (state == DONE) frame_avail <= 1'b0;
        if (pending) begin
          pending <= 1'b0;
          if (!capturing) begin
            rd_bank <= wr_bank; wr_bank <= ~wr_bank; frame_avail <= 1'b1;
          end
        end
      end
      if (last_blk) begin
        capturing <= 1'b0;
        if (rd_free) begin
          rd_bank <= wr_bank; wr_bank <= ~wr_bank; frame_avail <= 1'b1; pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end
`else
      // the reader owns the only bank, so a capture may only start while it is idle
      if (frame_start) begin
        if ((state == IDLE) && !rd_start) begin
          capturing <= 1'b1; frame_avail <= 1'b0;
        end else begin
          o_drop <= 1'b1;
        end
      end
      if ((state == DONE) && !i_rd_rdy) frame_avail <= 1'b0;
      if (last_blk) begin
        capturing <= 1'b0; frame_avail <= 1'b1;
      end
`endif
      if (vsync_rise && capturing) begin
        capturing <= 1'b0; o_drop <= 1'b1;
      end

      case (state)
        IDLE: if (rd_start) begin
          state <= READ; o_rd_req <= 1'b1; rd_addr <= '0; iss <= 1'b1;
        end
        READ: if (!i_rd_rdy) begin
          state <= IDLE; o_rd_req <= 1'b0; iss <= 1'b0;
        end else begin
          if (iss) begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_addr == LAST) iss <= 1'b0;
          end
          if (o_we && (o_waddr == 16'(N - 1))) begin
            state <= DONE; o_rd_req <= 1'b0; o_rd_done <= 1'b1;
          end
        end
        DONE: if (!i_rd_rdy) begin
          state <= IDLE; o_rd_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      v1   <= iss && (state == READ) && i_rd_rdy;
      a1   <= rd_addr;
      o_we <= v1 && (state == READ) && i_rd_rdy;
      if (v1) begin
        o_waddr <= 16'(a1);
        o_dout  <= {{8{~fb_q[7]}}, ~fb_q[7], fb_q[6:0]} << DOUT_SHIFT;
      end
    end
  end
endmodule

// File: tb/tb_ice40_video_downscale_fb_param.sv
// Directed bench for ice40_video_downscale_fb_param: 8x8 output, 2x2 blocks, crop at (32,4).
module tb_ice40_video_downscale_fb_param;
  localparam int NPIX   = 64;
  localparam int LINE_Q = 52;
  localparam int LINES  = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, i_cam_vsync, i_cam_de, i_cam_vld, i_rd_rdy;
  logic [7:0]  i_cam_data;
  logic [9:0]  o_width, o_height;
  logic        o_drop, o_rd_req, o_rd_done, o_we;
  logic [15:0] o_waddr, o_dout;

  ice40_video_downscale_fb_param #(
    .H_START(32), .V_START(4), .BLK_LOG2(1), .OUT_W(8), .OUT_H(8), .DOUT_SHIFT(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_cam_vsync(i_cam_vsync), .i_cam_de(i_cam_de), .i_cam_vld(i_cam_vld),
    .i_cam_data(i_cam_data), .o_width(o_width), .o_height(o_height), .o_drop(o_drop),
    .i_rd_rdy(i_rd_rdy), .o_rd_req(o_rd_req), .o_rd_done(o_rd_done),
    .o_we(o_we), .o_waddr(o_waddr), .o_dout(o_dout)
  );

  int n_chk = 0, n_pass = 0;
  int we_cnt = 0, order_err = 0, drop_cnt = 0, req_cnt = 0;
  logic [15:0] rec [NPIX];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // samples outputs on the falling edge, then returns just after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (o_drop) drop_cnt++;
      if (o_rd_req) req_cnt++;
      if (o_we) begin
        if (o_waddr != 16'(we_cnt)) order_err++;
        if (o_waddr < 16'(NPIX)) rec[o_waddr[5:0]] = o_dout;
        we_cnt++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] exp_dout(input int p);
    return 16'((p - 128) * 4);
  endfunction

  // mode 0: constant val, 1: pixel index ramp, 2: line index ramp
  task automatic send_frame(input int lines, input int mode, input logic [7:0] val);
    int q, k;
    i_cam_vsync = 1'b1; tick(4);
    i_cam_vsync = 1'b0; tick(4);
    for (int y = 0; y < lines; y++) begin
      q = 0; k = 0;
      while (q < LINE_Q) begin
        i_cam_de  = 1'b1;
        i_cam_vld = ((k % 7) != 6);
        if (i_cam_vld) begin
          i_cam_data = (mode == 0) ? val : (mode == 1) ? 8'(q) : 8'(y);
          q++;
        end else begin
          i_cam_data = 8'hFF;
        end
        k++;
        tick(1);
      end
      i_cam_de = 1'b0; i_cam_vld = 1'b0; tick(6);
    end
    i_cam_vsync = 1'b1; tick(6);
  endtask

  task automatic do_read(input string tag);
    int n = 0;
    we_cnt = 0; order_err = 0;
    i_rd_rdy = 1'b1;
    while (!o_rd_done && n < 300) begin tick(1); n++; end
    check({tag, "_done"}, {31'd0, o_rd_done}, 1);
    check({tag, "_we_cnt"}, we_cnt, NPIX);
    check({tag, "_order"}, order_err, 0);
  endtask

  task automatic wait_we(input string tag, input int addr);
    int n = 0;
    while (!(o_we && o_waddr == 16'(addr)) && n < 300) begin tick(1); n++; end
    check(tag, {31'd0, o_we && (o_waddr == 16'(addr))}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs, d0, r0;
    resetn = 1'b0; i_cam_vsync = 1'b1; i_cam_de = 1'b0; i_cam_vld = 1'b0;
    i_cam_data = 8'h00; i_rd_rdy = 1'b0;
    #23;
    check("rst_req",   {31'd0, o_rd_req}, 0);
    check("rst_done",  {31'd0, o_rd_done}, 0);
    check("rst_we",    {31'd0, o_we}, 0);
    check("rst_waddr", {16'd0, o_waddr}, 0);
    check("rst_dout",  {16'd0, o_dout}, 0);
    check("rst_dim",   {12'd0, o_width, o_height}, 0);
    check("rst_drop",  {31'd0, o_drop}, 0);
    @(negedge clk); resetn = 1'b1;
    tick(3);

    // horizontal ramp: column c averages to 2c+32
    send_frame(LINES, 1, 8'h00);
    check("t1_width",  {22'd0, o_width}, 52);
    check("t1_height", {22'd0, o_height}, 22);
    check("t1_drop",   drop_cnt, 0);
    do_read("t1");
    check("t1_c0", {16'd0, rec[0]}, 32'hFE80);
    check("t1_c3", {16'd0, rec[3]}, 32'hFE98);
    check("t1_last", {16'd0, rec[63]}, 32'hFEB8);
    errs = 0;
    for (int a = 0; a < NPIX; a++) if (rec[a] !== exp_dout(2 * (a % 8) + 32)) errs++;
    check("t1_table", errs, 0);
    i_rd_rdy = 1'b0; tick(2);
    check("t1_done_clr", {31'd0, o_rd_done}, 0);
    r0 = req_cnt; i_rd_rdy = 1'b1; tick(20);
    check("t1_no_reread", req_cnt - r0, 0);
    i_rd_rdy = 1'b0; tick(2);

    // vertical ramp with an abort mid-transfer, then full re-read
    send_frame(LINES, 2, 8'h00);
    i_rd_rdy = 1'b1;
    wait_we("t2_reach30", 30);
    i_rd_rdy = 1'b0; tick(2);
    check("t2_abort_we",  {31'd0, o_we}, 0);
    check("t2_abort_req", {31'd0, o_rd_req}, 0);
    do_read("t2");
    check("t2_r0", {16'd0, rec[0]}, 32'hFE10);
    check("t2_r3", {16'd0, rec[27]}, 32'hFE28);
    check("t2_r7", {16'd0, rec[63]}, 32'hFE48);
    errs = 0;
    for (int a = 0; a < NPIX; a++) if (rec[a] !== exp_dout(2 * (a / 8) + 4)) errs++;
    check("t2_table", errs, 0);
    i_rd_rdy = 1'b0; tick(2);

    // mid-gray frame, then a new frame arrives while the reader sits in DONE
    send_frame(LINES, 0, 8'h80);
    do_read("t3");
    errs = 0;
    for (int a = 0; a < NPIX; a++) if (rec[a] !== 16'h0000) errs++;
    check("t3_zero", errs, 0);
    d0 = drop_cnt;
    send_frame(LINES, 0, 8'h20);
`ifdef DS_PINGPONG_EN
    check("t3_nodrop", drop_cnt - d0, 0);
    i_rd_rdy = 1'b0; tick(2);
    do_read("t3b");
    errs = 0;
    for (int a = 0; a < NPIX; a++) if (rec[a] !== 16'hFE80) errs++;
    check("t3_newest", errs, 0);
`else
    check("t3_drop", drop_cnt - d0, 1);
    check("t3_still_done", {31'd0, o_rd_done}, 1);
    i_rd_rdy = 1'b0; tick(2);
    r0 = req_cnt; i_rd_rdy = 1'b1; tick(20);
    check("t3_no_req", req_cnt - r0, 0);
`endif
    i_rd_rdy = 1'b0; tick(2);

    // short frame: only 10 lines before vsync
    d0 = drop_cnt;
    send_frame(10, 0, 8'h40);
    check("t4_drop", drop_cnt - d0, 1);
    check("t4_height", {22'd0, o_height}, 10);
    r0 = req_cnt; i_rd_rdy = 1'b1; tick(30);
    check("t4_no_req", req_cnt - r0, 0);
    i_rd_rdy = 1'b0; tick(2);

    // asynchronous reset in the middle of a transfer
    send_frame(LINES, 1, 8'h00);
    i_rd_rdy = 1'b1;
    wait_we("t5_reach40", 40);
    #2 resetn = 1'b0;
    #1;
    check("t5_we",    {31'd0, o_we}, 0);
    check("t5_req",   {31'd0, o_rd_req}, 0);
    check("t5_waddr", {16'd0, o_waddr}, 0);
    check("t5_width", {22'd0, o_width}, 0);
    i_rd_rdy = 1'b0; tick(2);
    resetn = 1'b1; tick(3);
    r0 = req_cnt; i_rd_rdy = 1'b1; tick(10);
    check("t5_no_req", req_cnt - r0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
